// File: rtl/uart_periph_if.sv
// Processor-side bus of the UART peripheral: read/write strobes, byte address,
// write data and combinational read data.
interface uart_periph_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_periph.sv
// Memory-mapped UART: TXD/RXD/CON registers, 8N1 transmitter and receiver
// running independently, level interrupt on TX_DONE / RX_READY.
module uart_periph #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter logic [31:0] BASE         = 32'h40000018
) (
  input  logic          clk,
  input  logic          reset,
  uart_periph_if.slave  bus,
  input  logic          uart_rx,
  output logic          uart_tx,
  output logic          irq_uart
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF  = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF);
  localparam logic [31:0] ADDR_TXD = BASE;
  localparam logic [31:0] ADDR_RXD = BASE + 32'd4;
  localparam logic [31:0] ADDR_CON = BASE + 32'd8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // Bus decode
  logic hit_txd, hit_rxd, hit_con;
  logic txd_wr, con_wr, rxd_rd, con_rd;
  assign hit_txd = (bus.addr == ADDR_TXD);
  assign hit_rxd = (bus.addr == ADDR_RXD);
  assign hit_con = (bus.addr == ADDR_CON);
  assign txd_wr  = bus.wr & hit_txd;
  assign con_wr  = bus.wr & hit_con;
  assign rxd_rd  = bus.rd & hit_rxd;
  assign con_rd  = bus.rd & hit_con;

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:8];

  // Registered state
  state_e           tx_state, rx_state;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic [2:0]       tx_bit, rx_bit;
  logic [7:0]       tx_shift, rx_shift, rx_data;
  logic [1:0]       rx_sync, con_en;
  logic             tx_done, rx_ready;

  // Next-state values
  state_e           tx_state_nxt, rx_state_nxt;
  logic [CNT_W-1:0] tx_cnt_nxt, rx_cnt_nxt;
  logic [2:0]       tx_bit_nxt, rx_bit_nxt;
  logic [7:0]       tx_shift_nxt, rx_shift_nxt, rx_data_nxt;
  logic [1:0]       con_en_nxt;
  logic             tx_done_nxt, rx_ready_nxt, tx_done_set, rx_done_set;
  logic             tx_line_nxt, irq_nxt, rx_s, tx_busy;

  assign rx_s    = rx_sync[1];
  assign tx_busy = (tx_state != IDLE);

  // State register; uart_tx resets high asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= IDLE;
      rx_state <= IDLE;
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      tx_bit   <= '0;
      rx_bit   <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_sync  <= 2'b11;
      con_en   <= '0;
      tx_done  <= 1'b0;
      rx_ready <= 1'b0;
      uart_tx  <= 1'b1;
      irq_uart <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      rx_state <= rx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      rx_cnt   <= rx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      rx_bit   <= rx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      rx_shift <= rx_shift_nxt;
      rx_data  <= rx_data_nxt;
      rx_sync  <= {rx_sync[0], uart_rx};
      con_en   <= con_en_nxt;
      tx_done  <= tx_done_nxt;
      rx_ready <= rx_ready_nxt;
      uart_tx  <= tx_line_nxt;
      irq_uart <= irq_nxt;
    end
  end

  // TX next state: writes are only accepted in IDLE
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_done_set  = 1'b0;
    case (tx_state)
      IDLE: begin
        if (txd_wr) begin
          tx_state_nxt = START;
          tx_cnt_nxt   = '0;
          tx_shift_nxt = bus.wdata[7:0];
        end
      end
      START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_nxt = DATA;
          tx_cnt_nxt   = '0;
          tx_bit_nxt   = '0;
        end else begin
          tx_cnt_nxt = tx_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt = '0;
          if (tx_bit == 3'd7) tx_state_nxt = STOP;
          else                tx_bit_nxt   = tx_bit + 3'd1;
        end else begin
          tx_cnt_nxt = tx_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_nxt = IDLE;
          tx_cnt_nxt   = '0;
          tx_done_set  = 1'b1;
        end else begin
          tx_cnt_nxt = tx_cnt + CNT_W'(1);
        end
      end
      default: tx_state_nxt = IDLE;
    endcase
  end

  // TX output: line level of the upcoming state, registered into uart_tx
  always_comb begin
    tx_line_nxt = 1'b1;
    case (tx_state_nxt)
      START:   tx_line_nxt = 1'b0;
      DATA:    tx_line_nxt = tx_shift_nxt[tx_bit_nxt];
      default: tx_line_nxt = 1'b1;
    endcase
  end

  // RX next state: half-bit start validation, then centre sampling
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_done_set  = 1'b0;
    case (rx_state)
      IDLE: begin
        if (!rx_s) begin
          rx_state_nxt = START;
          rx_cnt_nxt   = '0;
        end
      end
      START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nxt = '0;
          rx_bit_nxt = '0;
          rx_state_nxt = rx_s ? IDLE : DATA;
        end else begin
          rx_cnt_nxt = rx_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_s, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_nxt = STOP;
          else                rx_bit_nxt   = rx_bit + 3'd1;
        end else begin
          rx_cnt_nxt = rx_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_state_nxt = IDLE;
          rx_cnt_nxt   = '0;
          rx_done_set  = rx_s;
        end else begin
          rx_cnt_nxt = rx_cnt + CNT_W'(1);
        end
      end
      default: rx_state_nxt = IDLE;
    endcase
  end

  // Flags: a set on the same edge as a read-clear wins
  always_comb begin
    con_en_nxt   = con_wr ? bus.wdata[1:0] : con_en;
    tx_done_nxt  = tx_done_set | (tx_done & ~con_rd);
    rx_ready_nxt = rx_done_set | (rx_ready & ~rxd_rd);
    rx_data_nxt  = rx_done_set ? rx_shift : rx_data;
    irq_nxt      = (con_en_nxt[0] & tx_done_nxt) | (con_en_nxt[1] & rx_ready_nxt);
  end

  // Combinational read mux
  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      if (hit_rxd) bus.rdata = {24'd0, rx_data};
      if (hit_con) bus.rdata = {27'd0, tx_busy, rx_ready, tx_done, con_en};
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// Directed bench for uart_periph at 16 clocks per bit: register map, TX/RX
// frames, false start, framing error, overrun, busy-write and mid-frame reset.
module tb_uart_periph;
  localparam int unsigned CPB = 16;
  localparam logic [31:0] TXD = 32'h40000018;
  localparam logic [31:0] RXD = 32'h4000001C;
  localparam logic [31:0] CON = 32'h40000020;

  logic clk = 1'b0;
  logic reset, uart_rx, uart_tx, irq_uart;
  logic [31:0] rv;
  int n_cmp = 0;
  int n_fail = 0;
  int lows;

  uart_periph_if bus();

  uart_periph #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .irq_uart(irq_uart)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    @(negedge clk);
    bus.rd = 1'b1; bus.addr = a;
    #1 d = bus.rdata;
    check(tag, d, exp);
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  // Checks every cycle of a frame starting at the negedge after the TXD write
  task automatic check_frame(input logic [7:0] b, input bit inject, input bit busy_chk);
    logic exp;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < CPB; c++) begin
        exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        bus.wr = inject && k == 0 && c == 0;
        bus.wdata = 32'h22;
        bus.addr = bus.wr ? TXD : CON;
        bus.rd = busy_chk && !bus.wr;
        #1;
        check($sformatf("tx_%02h_bit%0d_c%0d", b, k, c), {31'd0, uart_tx}, {31'd0, exp});
        if (bus.rd) check($sformatf("busy_%02h_bit%0d_c%0d", b, k, c), {31'd0, bus.rdata[4]}, 32'd1);
        @(negedge clk);
      end
    end
    bus.wr = 1'b0;
    bus.rd = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  initial begin
    reset = 1'b0; uart_rx = 1'b1;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_irq", {31'd0, irq_uart}, 32'd0);
    reset = 1'b1;
    read_check("rst_con", CON, 32'h0);
    read_check("rst_rxd", RXD, 32'h0);

    // Register map and decode
    bus_write(CON, 32'hFFFF_FFFF);
    read_check("con_mask", CON, 32'h03);
    bus_write(CON + 32'd4, 32'h0);
    read_check("miss_wr", CON, 32'h03);
    bus_write(CON, 32'h0);
    read_check("con_clr", CON, 32'h00);
    read_check("txd_rd", TXD, 32'h0);
    @(negedge clk);
    bus.addr = CON;
    #1 check("no_rd", bus.rdata, 32'h0);

    // TX 0xA5
    bus_write(TXD, 32'hA5);
    check_frame(8'hA5, 1'b0, 1'b0);
    check("a5_irq", {31'd0, irq_uart}, 32'd0);
    read_check("a5_con1", CON, 32'h04);
    read_check("a5_con2", CON, 32'h00);

    // TX 0x11 with ignored 0x22 write, busy polled each cycle, TX irq on
    bus_write(CON, 32'h01);
    bus_write(TXD, 32'h11);
    check_frame(8'h11, 1'b1, 1'b1);
    check("tx_irq_set", {31'd0, irq_uart}, 32'd1);
    read_check("tx_con_done", CON, 32'h05);
    check("tx_irq_clr", {31'd0, irq_uart}, 32'd0);
    read_check("tx_con_after", CON, 32'h01);
    @(negedge clk);
    check("tx_idle_hi", {31'd0, uart_tx}, 32'd1);

    // RX 0x3C with RX irq
    bus_write(CON, 32'h02);
    rx_frame(8'h3C, 1'b1);
    check("rx_irq_set", {31'd0, irq_uart}, 32'd1);
    read_check("rx_data", RXD, 32'h3C);
    check("rx_irq_clr", {31'd0, irq_uart}, 32'd0);
    read_check("rx_con", CON, 32'h02);

    // False start
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    read_check("false_start_con", CON, 32'h02);
    check("false_start_irq", {31'd0, irq_uart}, 32'd0);

    // Framing error
    rx_frame(8'h55, 1'b0);
    repeat (30) @(negedge clk);
    read_check("frame_err_con", CON, 32'h02);
    read_check("frame_err_rxd", RXD, 32'h3C);

    // Overrun: second byte overwrites, RX_READY stays set
    rx_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    rx_frame(8'h7E, 1'b1);
    read_check("ovr_con", CON, 32'h0A);
    read_check("ovr_rxd", RXD, 32'h7E);
    read_check("ovr_con_clr", CON, 32'h02);

    // Reset during TX DATA
    bus_write(TXD, 32'hF0);
    repeat (40) @(negedge clk);
    check("pre_rst_tx", {31'd0, uart_tx}, 32'd0);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
    check("mid_rst_irq", {31'd0, irq_uart}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    read_check("post_rst_con", CON, 32'h0);
    read_check("post_rst_rxd", RXD, 32'h0);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("post_rst_quiet", 32'(lows), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
